// File: rtl/axi4_sram_bridge.sv
// axi4_sram_bridge: single-beat bridge from the core SRAM-style requestor port to an AXI4 master.
// Latency: request sampled at cycle 0, mem_stall falls at cycle 3 with a zero-wait slave.
// Backpressure: mem_stall holds the requestor; every AXI VALID is held until its READY.
// Optional: define AXI4_SRAM_BRIDGE_ALIGN_CHECK_EN to fail misaligned requests without AXI traffic.
module axi4_sram_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  // AXI4 write address channel
  output logic [ADDR_W-1:0]   AWADDR,
  output logic                AWVALID,
  input  logic                AWREADY,
  // AXI4 write data channel
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  // AXI4 write response channel
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  // AXI4 read address channel
  output logic [ADDR_W-1:0]   ARADDR,
  output logic                ARVALID,
  input  logic                ARREADY,
  // AXI4 read data channel
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RVALID,
  output logic                RREADY,
  // SRAM-style requestor port
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_c_en,
  input  logic                mem_w_en,
  input  logic [DATA_W/8-1:0] mem_b_en,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_error,
  output logic                mem_stall
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RADDR,
    ST_RDATA,
    ST_WRITE,
    ST_WRESP,
    ST_DONE
  } state_t;

  state_t state;
  logic   err;
  logic   misaligned;

`ifdef AXI4_SRAM_BRIDGE_ALIGN_CHECK_EN
  localparam int OFF_W = $clog2(STRB_W);
  // Any set bit below the bus width makes the request unserviceable as a single beat.
  assign misaligned = |mem_addr[OFF_W-1:0];
`else
  // Low address bits pass straight through to AxADDR.
  assign misaligned = 1'b0;
`endif

  // Only the upper response bit distinguishes OKAY/EXOKAY from SLVERR/DECERR.
  logic unused_resp_bits;
  assign unused_resp_bits = &{1'b0, RRESP[0], BRESP[0]};

  // Handshake FSM; all AXI outputs and captured request fields are registered here.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= ST_IDLE;
      err       <= 1'b0;
      AWADDR    <= '0;
      AWVALID   <= 1'b0;
      WDATA     <= '0;
      WSTRB     <= '0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      ARADDR    <= '0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      mem_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_c_en) begin
            err <= 1'b0;
            if (misaligned) begin
              err   <= 1'b1;
              state <= ST_DONE;
            end else if (mem_w_en) begin
              AWADDR  <= mem_addr;
              WDATA   <= mem_wdata;
              WSTRB   <= mem_b_en;
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              state   <= ST_WRITE;
            end else begin
              ARADDR  <= mem_addr;
              ARVALID <= 1'b1;
              state   <= ST_RADDR;
            end
          end
        end
        ST_RADDR: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (RVALID) begin
            RREADY    <= 1'b0;
            mem_rdata <= RDATA;
            err       <= RRESP[1];
            state     <= ST_DONE;
          end
        end
        ST_WRITE: begin
          // AW and W retire independently; a channel already done stays low.
          if (AWREADY) AWVALID <= 1'b0;
          if (WREADY)  WVALID  <= 1'b0;
          if ((!AWVALID || AWREADY) && (!WVALID || WREADY)) begin
            BREADY <= 1'b1;
            state  <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (BVALID) begin
            BREADY <= 1'b0;
            err    <= BRESP[1];
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          // The request still presented here is the one just completed.
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign WLAST     = WVALID;
  assign mem_stall = ((state != ST_IDLE) && (state != ST_DONE)) ||
                     ((state == ST_IDLE) && mem_c_en);
  assign mem_error = (state == ST_DONE) ? err : 1'b0;

endmodule

// File: tb/tb_axi4_sram_bridge.sv
// tb_axi4_sram_bridge: directed vectors against a programmable-wait AXI slave model.
// Expected completions are queued at issue time and checked by an independent monitor.
module tb_axi4_sram_bridge;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_c_en;
  logic        mem_w_en;
  logic [3:0]  mem_b_en;
  logic [31:0] mem_rdata;
  logic        mem_error;
  logic        mem_stall;

  axi4_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_c_en(mem_c_en),
    .mem_w_en(mem_w_en), .mem_b_en(mem_b_en),
    .mem_rdata(mem_rdata), .mem_error(mem_error), .mem_stall(mem_stall)
  );

  always #5 ACLK = ~ACLK;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- slave model ----------------
  int          ar_wait, r_wait, aw_wait, w_wait, b_wait;
  int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  logic [31:0] s_rdata;
  logic [1:0]  s_resp;
  logic        p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
  logic [31:0] p_araddr, p_awaddr, p_wdata;
  logic [3:0]  p_wstrb;

  // Drives slave READY/VALID at the falling edge and checks VALID/payload hold rules.
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      ARREADY = 0; AWREADY = 0; WREADY = 0; RVALID = 0; BVALID = 0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
    end else begin
      if (p_arv && !p_arr) begin
        chk("arvalid_hold", ARVALID, 1);
        chk("araddr_stable", ARADDR, p_araddr);
      end
      if (p_awv && !p_awr) begin
        chk("awvalid_hold", AWVALID, 1);
        chk("awaddr_stable", AWADDR, p_awaddr);
      end
      if (p_wv && !p_wr) begin
        chk("wvalid_hold", WVALID, 1);
        chk("wdata_stable", {WSTRB, WDATA}, {p_wstrb, p_wdata});
      end
      if (ARVALID) begin ARREADY = (ar_cnt == ar_wait); ar_cnt++; end
      else begin ARREADY = 0; ar_cnt = 0; end
      if (AWVALID) begin AWREADY = (aw_cnt == aw_wait); aw_cnt++; end
      else begin AWREADY = 0; aw_cnt = 0; end
      if (WVALID) begin WREADY = (w_cnt == w_wait); w_cnt++; end
      else begin WREADY = 0; w_cnt = 0; end
      if (RREADY) begin RVALID = (r_cnt == r_wait); r_cnt++; end
      else begin RVALID = 0; r_cnt = 0; end
      if (BREADY) begin BVALID = (b_cnt == b_wait); b_cnt++; end
      else begin BVALID = 0; b_cnt = 0; end
      p_arv = ARVALID; p_arr = ARREADY; p_araddr = ARADDR;
      p_awv = AWVALID; p_awr = AWREADY; p_awaddr = AWADDR;
      p_wv = WVALID; p_wr = WREADY; p_wdata = WDATA; p_wstrb = WSTRB;
    end
    RDATA = RVALID ? s_rdata : 32'h0;
    RRESP = RVALID ? s_resp : 2'b00;
    BRESP = BVALID ? s_resp : 2'b00;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  logic req_active = 1'b0;
  int   start_cyc  = 0;

  // Pops the expected completion when the bridge releases the requestor.
  always @(posedge ACLK) begin
    #1;
    if (req_active && ARESETn && !mem_stall) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_completion", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.nm, "_rdata"}, mem_rdata, e.rd);
        chk({e.nm, "_error"}, mem_error, e.err);
        chk({e.nm, "_latency"}, cyc - start_cyc, e.lat);
      end
    end else if (ARESETn) begin
      chk("mem_error_outside_done", mem_error, 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic run(input string nm, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] ben,
                     input int aw, input int w, input int b, input int ar, input int r,
                     input logic [31:0] rd, input logic [1:0] resp,
                     input logic [31:0] exp_rd, input bit exp_err, input int exp_lat,
                     input int tid);
    exp_t e;
    int   k;
    bit   done;
    aw_wait = aw; w_wait = w; b_wait = b; ar_wait = ar; r_wait = r;
    s_rdata = rd; s_resp = resp;
    @(negedge ACLK);
    mem_addr = addr; mem_wdata = wdata; mem_b_en = ben; mem_w_en = wr; mem_c_en = 1'b1;
    start_cyc = cyc; req_active = 1'b1;
    e.rd = exp_rd; e.err = exp_err; e.lat = exp_lat; e.nm = nm;
    exp_q.push_back(e);
    k = 0; done = 0;
    while (!done && k < 60) begin
      @(negedge ACLK);
      k++;
      case (tid)
        1: begin
          if (k == 1) begin
            chk("wr_aw_w_start", {AWVALID, WVALID, WLAST}, 3'b111);
            chk("wr_wstrb", WSTRB, 4'h3);
            chk("wr_wdata", WDATA, 32'h12345678);
            chk("wr_awaddr", AWADDR, 32'h2000);
          end
          if (k == 2) chk("wr_wvalid_drop", {AWVALID, WVALID, WLAST}, 3'b100);
          if (k == 3) chk("wr_bready_early", {AWVALID, BREADY}, 2'b10);
          if (k == 4) chk("wr_awvalid_drop_bready", {AWVALID, BREADY}, 2'b01);
        end
        2: begin
          if (k <= 6) chk("rd_wait_rready_low", {ARVALID, RREADY}, 2'b10);
          if (k == 7) chk("rd_wait_rready_high", {ARVALID, RREADY}, 2'b01);
        end
        3: chk("misalign_no_arvalid", ARVALID, 0);
        4: if (k == 1) chk("unaligned_araddr", ARADDR, 32'h1002);
        default: ;
      endcase
      if (!mem_stall) done = 1;
    end
    if (!done) chk({nm, "_timeout"}, 1, 0);
    mem_c_en = 1'b0; req_active = 1'b0;
  endtask

  initial begin
    ARESETn = 1'b0;
    mem_addr = 0; mem_wdata = 0; mem_c_en = 0; mem_w_en = 0; mem_b_en = 0;
    ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
    s_rdata = 0; s_resp = 0;
    #3;
    chk("rst_valids", {AWVALID, WVALID, WLAST, ARVALID}, 4'b0000);
    chk("rst_readys", {BREADY, RREADY}, 2'b00);
    chk("rst_addrs", {AWADDR, ARADDR}, 64'h0);
    chk("rst_wdata_wstrb", {WSTRB, WDATA}, 36'h0);
    chk("rst_mem_out", {mem_error, mem_stall, mem_rdata}, 34'h0);
    @(negedge ACLK); @(posedge ACLK); #2 ARESETn = 1'b1;

    run("rd_basic", 0, 32'h1000, 0, 4'h0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 2'b00,
        32'hDEADBEEF, 0, 3, 0);
    run("wr_split", 1, 32'h2000, 32'h12345678, 4'h3, 2, 0, 1, 0, 0, 0, 2'b00,
        32'hDEADBEEF, 0, 6, 1);
    run("rd_arwait", 0, 32'h3000, 0, 4'h0, 0, 0, 0, 5, 0, 32'hCAFEF00D, 2'b00,
        32'hCAFEF00D, 0, 8, 2);
    run("wr_slverr", 1, 32'h4000, 32'hAABBCCDD, 4'hF, 0, 0, 0, 0, 0, 0, 2'b10,
        32'hCAFEF00D, 1, 3, 0);
    @(negedge ACLK);
    chk("slverr_error_after_done", {mem_error, mem_stall}, 2'b00);
    run("wr_aw_first_decerr", 1, 32'h4004, 32'h0, 4'h1, 0, 2, 0, 0, 0, 0, 2'b11,
        32'hCAFEF00D, 1, 5, 0);
    run("wr_exokay", 1, 32'h4008, 32'h1, 4'hC, 0, 0, 0, 0, 0, 0, 2'b01,
        32'hCAFEF00D, 0, 3, 0);
    run("rd_decerr", 0, 32'h5000, 0, 4'h0, 0, 0, 0, 0, 0, 32'h55AA55AA, 2'b11,
        32'h55AA55AA, 1, 3, 0);
    run("rd_exokay", 0, 32'h5004, 0, 4'h0, 0, 0, 0, 0, 1, 32'h01020304, 2'b01,
        32'h01020304, 0, 4, 0);

    // Reset in the middle of a stalled write.
    aw_wait = 20; w_wait = 20;
    @(negedge ACLK);
    mem_addr = 32'h7000; mem_wdata = 32'h77777777; mem_b_en = 4'hF;
    mem_w_en = 1'b1; mem_c_en = 1'b1;
    @(negedge ACLK);
    chk("midrst_write_active", {AWVALID, WVALID}, 2'b11);
    @(posedge ACLK); #2 ARESETn = 1'b0; mem_c_en = 1'b0;
    #1;
    chk("midrst_valids_zero", {AWVALID, WVALID, ARVALID}, 3'b000);
    chk("midrst_readys_zero", {BREADY, RREADY}, 2'b00);
    chk("midrst_regs_zero", {WSTRB, AWADDR}, 36'h0);
    @(negedge ACLK); @(posedge ACLK); #2 ARESETn = 1'b1;
    @(negedge ACLK);
    chk("postrst_idle", {mem_stall, AWVALID, WVALID}, 3'b000);
    run("rd_after_reset", 0, 32'h6000, 0, 4'h0, 0, 0, 0, 0, 0, 32'h0BADF00D, 2'b00,
        32'h0BADF00D, 0, 3, 0);

`ifdef AXI4_SRAM_BRIDGE_ALIGN_CHECK_EN
    run("rd_misaligned", 0, 32'h1002, 0, 4'h0, 0, 0, 0, 0, 0, 32'h13572468, 2'b00,
        32'h0BADF00D, 1, 1, 3);
`else
    run("rd_unaligned_pass", 0, 32'h1002, 0, 4'h0, 0, 0, 0, 0, 0, 32'h13572468, 2'b00,
        32'h13572468, 0, 3, 4);
`endif

    repeat (3) @(negedge ACLK);
    chk("sb_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi4_sram_bridge.md
# axi4_sram_bridge

Parametrised single-beat bridge from the core's SRAM-style requestor port (chip/write/byte enable plus stall/error) onto an AXI4 master port. It replaces the fixed 32-bit, pipeline-register bridge with an explicit handshake FSM:
- every AXI VALID is held until its READY;
- AW and W complete independently;
- write responses are checked.

It sits between the core's memory stage and the system interconnect.
## Interface
Parameters:
- ADDR_W, 32, address width of mem_addr, AWADDR and ARADDR.
- DATA_W, 32, data width; 32 or 64 only. STRB_W = DATA_W/8.

Ports (AxLEN=0, AxBURST=INCR, IDs=0 and AxSIZE=log2(STRB_W) are fixed; the interconnect wrapper ties them):
- ACLK  in  1  clock; all logic is rising-edge.
- ARESETn  in  1  asynchronous, active-low reset.
- AWADDR  out  ADDR_W  write address, registered.
- AWVALID  out  1  write address valid.
- AWREADY  in  1  slave write-address ready.
- WDATA  out  DATA_W  write data, registered.
- WSTRB  out  STRB_W  write strobes, registered from mem_b_en.
- WLAST  out  1  equal to WVALID (single beat).
- WVALID  out  1  write data valid.
- WREADY  in  1  slave write-data ready.
- BRESP  in  2  write response.
- BVALID  in  1  write response valid.
- BREADY  out  1  master response ready.
- ARADDR  out  ADDR_W  read address, registered.
- ARVALID  out  1  read address valid.
- ARREADY  in  1  slave read-address ready.
- RDATA  in  DATA_W  read data.
- RRESP  in  2  read response.
- RVALID  in  1  read data valid.
- RREADY  out  1  master read ready.
- mem_addr  in  ADDR_W  request address.
- mem_wdata  in  DATA_W  request write data.
- mem_c_en  in  1  request present.
- mem_w_en  in  1  1 = write, 0 = read.
- mem_b_en  in  STRB_W  write byte enables; ignored for reads.
- mem_rdata  out  DATA_W  read data, registered; valid in the cycle mem_stall falls.
- mem_error  out  1  error for the completed request; valid with mem_rdata.
- mem_stall  out  1  requestor must hold its inputs while this is high.
## Operation
- FSM states: IDLE, RADDR, RDATA, WRITE, WRESP, DONE. One request is in flight at a time.
- IDLE, mem_c_en=1:
  - Capture addr/wdata/b_en.
  - If mem_w_en=0: go to RADDR. If mem_w_en=1: go to WRITE.
- RADDR: ARVALID=1 until ARREADY, then go to RDATA.
- RDATA: RREADY=1. On RVALID: mem_rdata<=RDATA, err<=RRESP[1], go to DONE.
- WRITE: AWVALID and WVALID both start high.
  - Each drops the cycle after its own READY handshake; the two may complete in either order or the same cycle.
  - Go to WRESP once both handshakes are done.
- WRESP: BREADY=1. On BVALID: err<=BRESP[1], mem_rdata unchanged, go to DONE.
- DONE: mem_stall=0 for one cycle, then go to IDLE. A request still presented in DONE is treated as the one just completed; a new request is sampled in IDLE.
- mem_stall = (state!=IDLE && state!=DONE) || (state==IDLE && mem_c_en).
- mem_error = err in DONE, else 0. OKAY and EXOKAY give 0; SLVERR and DECERR give 1.
- VALID never drops before its READY handshake. Address and data outputs stay stable while VALID is high.
## Timing
- Reset (asynchronous, immediate): state=IDLE; all VALID and READY outputs 0; AWADDR, ARADDR, WDATA, WSTRB and mem_rdata 0; mem_error 0. Reset mid-transaction abandons the transaction.
- Read latency with zero-wait slave: request sampled at cycle 0; ARVALID at cycle 1; RREADY at cycle 2; mem_stall low at cycle 3.
- Write latency, same conditions: request at 0; AW/W handshakes at 1; BREADY at 2; mem_stall low at 3.
- Throughput: at most one request per 4 cycles.
## Configuration
- AXI4_SRAM_BRIDGE_ALIGN_CHECK_EN defined: in IDLE, a request with mem_addr[log2(STRB_W)-1:0]!=0 issues no AXI transaction and goes straight to DONE with err=1 and mem_rdata unchanged. mem_stall falls at cycle 1.
- Undefined: the low address bits pass unchanged onto AxADDR and no check is made.
## Test plan
- Read 0x1000, ARREADY/RVALID immediate, RDATA=0xDEADBEEF, RRESP=OKAY -> mem_stall low at cycle 3; mem_rdata=0xDEADBEEF; mem_error=0.
- Write 0x2000, wdata 0x12345678, b_en 0x3; WREADY at cycle 1, AWREADY at cycle 3 -> WVALID drops at 2, AWVALID drops at 4; WSTRB=0x3; BREADY first at 4; BVALID at 5 -> mem_stall low at 6.
- Read with ARREADY held low 5 cycles -> ARVALID and ARADDR stable throughout; RREADY stays 0 until the AR handshake.
- Write with BRESP=SLVERR (2'b10) -> mem_error=1 for exactly the DONE cycle, then 0.
- ARESETn pulsed low while in WRITE with AWVALID=1 -> all VALIDs 0 immediately; after release, state IDLE and next read completes normally.
- ALIGN_CHECK_EN defined, read at 0x1002 -> ARVALID never rises; mem_error=1 and mem_stall=0 at cycle 1.
